pe_result_accumulator: RTL

//  Receiving end of the PE result interface: takes 6x6 Winograd output tiles (result_tile/address/valid)

---
 rtl/winocnn_pkg.sv | 22 ++
 rtl/result_fifo.sv | 55 +++++
 rtl/pe_result_accumulator.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/winocnn_pkg.sv
// Shared Winograd CNN definitions: tile geometry, default element widths and accumulator FSM states.
// Used by the PE, input/weight transforms and the result accumulator.
package winocnn_pkg;

  localparam int TILE_N    = 6;
  localparam int IN_W_DEF  = 12;
  localparam int ACC_W_DEF = 16;

  typedef logic [TILE_N-1:0][TILE_N-1:0][IN_W_DEF-1:0]  in_tile_t;
  typedef logic [TILE_N-1:0][TILE_N-1:0][ACC_W_DEF-1:0] acc_tile_t;

  typedef enum logic {
    CLEAR,
    RUN
  } acc_state_t;

  // A 3x3 convolution produces a 4x4 output tile in the top-left corner of the 6x6 grid.
  function automatic logic in_small_tile(input int row, input int col);
    return (row < 4) && (col < 4);
  endfunction

endpackage

// File: rtl/result_fifo.sv
// Show-ahead synchronous FIFO for finished tiles; the head word is visible whenever empty is low.
// flush empties the queue in one cycle without touching stored data.
module result_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head_data,
  output logic              empty,
  output logic              full
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W:0]    wr_ptr;
  logic [PTR_W:0]    rd_ptr;
  logic              do_push;
  logic              do_pop;

  // The extra pointer bit tells full from empty when the index bits match.
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                     (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign do_pop    = pop && !empty;
  assign do_push   = push && (!full || do_pop);
  assign head_data = mem[rd_ptr[PTR_W-1:0]];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_push && !flush) begin
      mem[wr_ptr[PTR_W-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/pe_result_accumulator.sv
// Sums partial Winograd output tiles over input channels per address and queues finished tiles.
// Build option: define ACC_SAT_EN for saturating adds; otherwise adds wrap in two's complement.
module pe_result_accumulator
  import winocnn_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int IN_W       = IN_W_DEF,
  parameter int ACC_W      = ACC_W_DEF,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                                     clk,
  input  logic                                     reset_n,
  input  logic                                     start_i,
  input  logic [4:0]                               num_ch_i,
  input  logic [TILE_N-1:0][TILE_N-1:0][IN_W-1:0]  result_tile_i,
  input  logic [ADDR_W-1:0]                        result_address_i,
  input  logic                                     result_valid_i,
  input  logic                                     size_type_i,
  output logic [TILE_N-1:0][TILE_N-1:0][ACC_W-1:0] out_tile_o,
  output logic [ADDR_W-1:0]                        out_address_o,
  output logic                                     out_valid_o,
  input  logic                                     out_ready_i,
  output logic                                     busy_o,
  output logic                                     overflow_o
);

  localparam int ENTRIES = 2 ** ADDR_W;
  localparam int TILE_W  = TILE_N * TILE_N * ACC_W;

  typedef logic [TILE_N-1:0][TILE_N-1:0][ACC_W-1:0] sum_tile_t;
  typedef logic [TILE_N-1:0][TILE_N-1:0][IN_W-1:0]  part_tile_t;

  acc_state_t        state;
  acc_state_t        state_next;
  logic [ADDR_W-1:0] clear_addr;
  logic [4:0]        num_ch;

  sum_tile_t         acc_mem [ENTRIES];
  logic [4:0]        cnt_mem [ENTRIES];

  logic              s1_valid;
  part_tile_t        s1_tile;
  logic [ADDR_W-1:0] s1_addr;
  logic              s1_size;
  sum_tile_t         s1_entry;
  logic [4:0]        s1_count;

  sum_tile_t         sum;
  logic [ACC_W-1:0]  ext;
  logic [4:0]        count_next;
  logic              done;
  sum_tile_t         wb_entry;
  logic [4:0]        wb_count;

  logic              accept;
  logic              push;
  logic              fifo_full;
  logic              fifo_empty;
  logic              drop;

`ifdef ACC_SAT_EN
  logic [ACC_W:0]    wide;
`endif

  always_comb begin
    state_next = state;
    case (state)
      CLEAR:   if (!start_i && (&clear_addr)) state_next = RUN;
      RUN:     if (start_i) state_next = CLEAR;
      default: state_next = CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= CLEAR;
      clear_addr <= '0;
      num_ch     <= 5'd1;
    end else begin
      state <= state_next;
      if (start_i) begin
        clear_addr <= '0;
        num_ch     <= (num_ch_i == 5'd0) ? 5'd1 : num_ch_i;
      end else if (state == CLEAR) begin
        clear_addr <= clear_addr + 1'b1;
      end
    end
  end

  assign accept = (state == RUN) && result_valid_i && !start_i;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1_tile  <= '0;
      s1_addr  <= '0;
      s1_size  <= 1'b0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_tile <= result_tile_i;
        s1_addr <= result_address_i;
        s1_size <= size_type_i;
      end
    end
  end

  // A tile to the address stage 1 is writing this edge must see that write, not the stale RAM word.
  always_ff @(posedge clk) begin
    if (accept) begin
      if (s1_valid && (s1_addr == result_address_i)) begin
        s1_entry <= wb_entry;
        s1_count <= wb_count;
      end else begin
        s1_entry <= acc_mem[result_address_i];
        s1_count <= cnt_mem[result_address_i];
      end
    end
  end

  always_comb begin
    sum = '0;
    ext = '0;
`ifdef ACC_SAT_EN
    wide = '0;
`endif
    for (int r = 0; r < TILE_N; r++) begin
      for (int c = 0; c < TILE_N; c++) begin
        ext = {{(ACC_W-IN_W){s1_tile[r][c][IN_W-1]}}, s1_tile[r][c]};
`ifdef ACC_SAT_EN
        wide = {s1_entry[r][c][ACC_W-1], s1_entry[r][c]} + {ext[ACC_W-1], ext};
        if (wide[ACC_W] != wide[ACC_W-1])
          sum[r][c] = wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        else
          sum[r][c] = wide[ACC_W-1:0];
`else
        sum[r][c] = s1_entry[r][c] + ext;
`endif
        if (s1_size && !in_small_tile(r, c)) sum[r][c] = '0;
      end
    end
  end

  assign count_next = s1_count + 5'd1;
  assign done       = (count_next == num_ch);
  assign wb_entry   = done ? '0 : sum;
  assign wb_count   = done ? 5'd0 : count_next;

  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      acc_mem[clear_addr] <= '0;
      cnt_mem[clear_addr] <= 5'd0;
    end else if (s1_valid && !start_i) begin
      acc_mem[s1_addr] <= wb_entry;
      cnt_mem[s1_addr] <= wb_count;
    end
  end

  assign push = s1_valid && done && !start_i;
  assign drop = push && fifo_full && !out_ready_i;

  result_fifo #(
    .DATA_W (TILE_W + ADDR_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (start_i),
    .push      (push),
    .push_data ({sum, s1_addr}),
    .pop       (out_ready_i),
    .head_data ({out_tile_o, out_address_o}),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  assign out_valid_o = !fifo_empty;
  assign busy_o      = (state == CLEAR);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      overflow_o <= 1'b0;
    else if (drop || ((state == CLEAR) && result_valid_i))
      overflow_o <= 1'b1;
  end

endmodule
